// File: rtl/uart_pkg.sv
// Shared UART constants used by the transmit datapath.
package uart_pkg;

  localparam int UART_TX_FIFO_DEPTH = 16;
  localparam logic [7:0] UART_FIFO_RST_DATA = 8'hFF;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit holding FIFO between THR writes and the serialiser, with level,
// threshold, empty-event and sticky overflow status.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  output logic [7:0]    tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  input  logic [AW:0]   cfg_thresh_i,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          below_thresh_o,
  output logic          empty_evt_o,
  output logic          overflow_o,
  input  logic          ovf_clr_i
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   level_q;
  logic          overflow_q;
  logic          empty_evt_q;

  logic pop;
  logic push;
  logic ovf_set;

  // Handshake: a byte transfers to the serialiser on any clock edge where
  // tx_valid_o && tx_ready_i; while valid is high and no transfer happens,
  // tx_data_o holds. The write side has no backpressure: a push into a full
  // FIFO without a concurrent pop is dropped and flagged as overflow.
  assign pop     = tx_valid_o && tx_ready_i;
  assign push    = wr_en_i && (!full_o || pop);
  assign ovf_set = wr_en_i && full_o && !pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      empty_evt_q <= 1'b0;
    end else if (clr_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      empty_evt_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= wr_data_i;
        wr_ptr_q      <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
      // Set beats a same-cycle software clear so a drop is never lost.
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr_i) begin
        overflow_q <= 1'b0;
      end
      empty_evt_q <= pop && !push && (level_q == LVL_ONE);
    end
  end

  assign level_o        = level_q;
  assign full_o         = (level_q == LVL_FULL);
  assign empty_o        = (level_q == '0);
  assign tx_valid_o     = !empty_o;
  assign tx_data_o      = empty_o ? UART_FIFO_RST_DATA : mem[rd_ptr_q];
  assign below_thresh_o = (level_q <= cfg_thresh_i);
  assign overflow_o     = overflow_q;
  assign empty_evt_o    = empty_evt_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for basic push/pop and
// hand-written sequences for full, overflow, flush and reset corner cases.
module tb_uart_tx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clr_i;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic [4:0] cfg_thresh_i;
  logic [4:0] level_o;
  logic       full_o;
  logic       empty_o;
  logic       below_thresh_o;
  logic       empty_evt_o;
  logic       overflow_o;
  logic       ovf_clr_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (clr_i),
    .wr_en_i        (wr_en_i),
    .wr_data_i      (wr_data_i),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .cfg_thresh_i   (cfg_thresh_i),
    .level_o        (level_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .below_thresh_o (below_thresh_o),
    .empty_evt_o    (empty_evt_o),
    .overflow_o     (overflow_o),
    .ovf_clr_i      (ovf_clr_i)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_ready;
    logic [4:0] thresh;
    logic [4:0] e_level;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_empty;
    logic       e_below;
    logic       e_evt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en_i   = 1'b1;
    wr_data_i = d;
    tick();
    wr_en_i   = 1'b0;
  endtask

  // Drain with ready held high, comparing each head against exp_q.
  task automatic drain(input string name);
    int guard;
    guard = 0;
    tx_ready_i = 1'b1;
    while (exp_q.size() > 0 && guard < 40) begin
      if (tx_valid_o) begin
        chk(name, {24'h0, tx_data_o}, {24'h0, exp_q.pop_front()});
      end
      tick();
      guard++;
    end
    tx_ready_i = 1'b0;
    if (exp_q.size() > 0) begin
      chk({name, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    // wr_en, data, ready, thresh | level, valid, data, empty, below, evt
    vecs[0] = '{1'b0, 8'h00, 1'b0, 5'd4, 5'd0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'h11, 1'b0, 5'd4, 5'd0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h22, 1'b0, 5'd4, 5'd1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h33, 1'b0, 5'd2, 5'd2, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 5'd2, 5'd3, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd4, 5'd3, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 5'd4, 5'd2, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 5'd4, 5'd1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 5'd4, 5'd0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 5'd4, 5'd0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};

    rst_i = 1'b1; clr_i = 1'b0; wr_en_i = 1'b0; wr_data_i = 8'h00;
    tx_ready_i = 1'b0; cfg_thresh_i = 5'd4; ovf_clr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    chk("rst_full", full_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);

    // table: inputs driven just after an edge, outputs sampled on the falling edge
    for (int i = 0; i < 10; i++) begin
      wr_en_i      = vecs[i].wr_en;
      wr_data_i    = vecs[i].wr_data;
      tx_ready_i   = vecs[i].tx_ready;
      cfg_thresh_i = vecs[i].thresh;
      @(negedge clk_i);
      chk($sformatf("v%0d_level", i), level_o, vecs[i].e_level);
      chk($sformatf("v%0d_valid", i), tx_valid_o, vecs[i].e_valid);
      chk($sformatf("v%0d_data", i), tx_data_o, vecs[i].e_data);
      chk($sformatf("v%0d_empty", i), empty_o, vecs[i].e_empty);
      chk($sformatf("v%0d_below", i), below_thresh_o, vecs[i].e_below);
      chk($sformatf("v%0d_evt", i), empty_evt_o, vecs[i].e_evt);
      tick();
    end
    wr_en_i = 1'b0; tx_ready_i = 1'b0; cfg_thresh_i = 5'd4;

    // fill to full, then a dropped 17th push
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    chk("fill_full", full_o, 1'b1);
    chk("fill_level", level_o, 5'd16);
    chk("fill_ovf0", overflow_o, 1'b0);
    push(8'hAA);
    chk("ovf_set", overflow_o, 1'b1);
    chk("ovf_level", level_o, 5'd16);
    chk("ovf_head", tx_data_o, 8'h40);
    cfg_thresh_i = 5'd15; #1;
    chk("thr15_full", below_thresh_o, 1'b0);
    cfg_thresh_i = 5'd16; #1;
    chk("thr16_full", below_thresh_o, 1'b1);
    cfg_thresh_i = 5'd31; #1;
    chk("thr31_full", below_thresh_o, 1'b1);
    cfg_thresh_i = 5'd4;

    // push+pop while full keeps the level and queues the new byte
    tx_ready_i = 1'b1;
    push(8'h55);
    tx_ready_i = 1'b0;
    chk("pp_level", level_o, 5'd16);
    chk("pp_head", tx_data_o, 8'h41);
    for (int i = 1; i < 16; i++) exp_q.push_back(8'h40 + 8'(i));
    exp_q.push_back(8'h55);
    drain("full_drain");
    chk("drain_empty", empty_o, 1'b1);
    chk("drain_evt", empty_evt_o, 1'b1);
    chk("drain_ovf", overflow_o, 1'b1);

    // threshold steps 3,4,5 with threshold 4
    push(8'h01); push(8'h02); push(8'h03);
    chk("thr_l3", below_thresh_o, 1'b1);
    push(8'h04);
    chk("thr_l4", below_thresh_o, 1'b1);
    push(8'h05);
    chk("thr_l5", below_thresh_o, 1'b0);
    chk("thr_level", level_o, 5'd5);

    // flush wins over a same-cycle push and clears overflow
    clr_i = 1'b1;
    push(8'h99);
    clr_i = 1'b0;
    chk("clr_level", level_o, 5'd0);
    chk("clr_ovf", overflow_o, 1'b0);
    chk("clr_evt", empty_evt_o, 1'b0);
    chk("clr_data", tx_data_o, 8'hFF);
    tick();
    chk("clr_evt_next", empty_evt_o, 1'b0);

    // overflow set beats a simultaneous ovf_clr; a lone ovf_clr clears it
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    ovf_clr_i = 1'b1;
    push(8'hBB);
    ovf_clr_i = 1'b0;
    chk("setwins_ovf", overflow_o, 1'b1);
    chk("setwins_head", tx_data_o, 8'h80);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    chk("ovfclr", overflow_o, 1'b0);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;

    // reset mid-drain with 5 entries queued
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    chk("rd_head0", tx_data_o, 8'h60);
    tx_ready_i = 1'b1;
    tick();
    chk("rd_head1", tx_data_o, 8'h61);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", tx_valid_o, 1'b0);
    chk("arst_level", level_o, 5'd0);
    chk("arst_data", tx_data_o, 8'hFF);
    chk("arst_empty", empty_o, 1'b1);
    tx_ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    chk("post_rst_evt", empty_evt_o, 1'b0);
    chk("post_rst_level", level_o, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
